// File: rtl/instr_loader_if.sv
// Byte-stream input and CPU instruction-load side of the boot loader.
// slave modport faces the loader; master faces the byte source / observer.
interface instr_loader_if #(
    parameter int NUM_WORDS = 32
);
    localparam int WCW = $clog2(NUM_WORDS + 1);

    logic            start;
    logic [7:0]      byte_in;
    logic            byte_valid;
    logic            byte_last;
    logic            byte_ready;
    logic            LoadInstructions;
    logic [31:0]     Instruction;
    logic            cpu_reset;
    logic [WCW-1:0]  word_count;
    logic            busy;
    logic            done;
    logic            err;

    modport slave (
        input  start, byte_in, byte_valid, byte_last,
        output byte_ready, LoadInstructions, Instruction, cpu_reset,
               word_count, busy, done, err
    );

    modport master (
        output start, byte_in, byte_valid, byte_last,
        input  byte_ready, LoadInstructions, Instruction, cpu_reset,
               word_count, busy, done, err
    );
endinterface

// File: rtl/instr_loader.sv
// Packs a byte stream into 32-bit words and strobes them into CPU instruction memory,
// holding the CPU in reset while loading; word strobe one cycle after its final byte.
module instr_loader #(
    parameter int NUM_WORDS  = 32,
    parameter int BOOT_HOLD  = 2,
    parameter int BIG_ENDIAN = 1
) (
    input  logic          clk,
    input  logic          Reset,
    instr_loader_if.slave bus
);
    localparam int WCW = $clog2(NUM_WORDS + 1);
    localparam int HCW = $clog2(BOOT_HOLD + 1);
    localparam logic [WCW-1:0] MAX_WORDS = WCW'(NUM_WORDS);
    localparam logic [WCW-1:0] WC_ONE    = WCW'(1);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(BOOT_HOLD);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);

    typedef enum logic [2:0] {IDLE, PRIME, COLLECT, WRITE, HOLD, RUN} state_t;

    state_t          state, stateNext;
    logic [1:0]      byteIdx;
    logic [31:0]     asmWord, asmNext, instrQ;
    logic            lastSeen, errQ;
    logic [WCW-1:0]  wordCount;
    logic [HCW-1:0]  holdCnt;
    logic            xfer, wordEnd, loadEnd;
    logic [4:0]      laneShift;
    logic            byteReady, loadStrobe, cpuReset, busyQ, doneQ;

    assign xfer    = bus.byte_valid && (state == COLLECT);
    assign wordEnd = xfer && ((byteIdx == 2'd3) || bus.byte_last);
    assign loadEnd = lastSeen || ((wordCount + WC_ONE) == MAX_WORDS);

    // ~byteIdx equals 3-byteIdx, so the first byte lands in [31:24] when big-endian
    assign laneShift = (BIG_ENDIAN != 0) ? {~byteIdx, 3'b000} : {byteIdx, 3'b000};
    assign asmNext   = asmWord | ({24'd0, bus.byte_in} << laneShift);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        byteReady  = 1'b0;
        loadStrobe = 1'b0;
        cpuReset   = 1'b1;
        busyQ      = 1'b0;
        doneQ      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) stateNext = PRIME;
            end
            PRIME: begin
                busyQ     = 1'b1;
                stateNext = COLLECT;
            end
            COLLECT: begin
                busyQ     = 1'b1;
                byteReady = 1'b1;
                if (wordEnd) stateNext = WRITE;
            end
            WRITE: begin
                busyQ      = 1'b1;
                loadStrobe = 1'b1;
                stateNext  = loadEnd ? HOLD : COLLECT;
            end
            HOLD: begin
                busyQ = 1'b1;
                if (holdCnt == HOLD_ONE) stateNext = RUN;
            end
            RUN: begin
                cpuReset = 1'b0;
                doneQ    = 1'b1;
                if (bus.start) stateNext = PRIME;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            byteIdx   <= '0;
            asmWord   <= '0;
            instrQ    <= '0;
            lastSeen  <= 1'b0;
            errQ      <= 1'b0;
            wordCount <= '0;
            holdCnt   <= '0;
        end else begin
            case (state)
                PRIME: begin
                    byteIdx   <= '0;
                    asmWord   <= '0;
                    lastSeen  <= 1'b0;
                    errQ      <= 1'b0;
                    wordCount <= '0;
                end
                COLLECT: begin
                    if (xfer) begin
                        byteIdx <= byteIdx + 2'd1;
                        asmWord <= asmNext;
                        if (wordEnd) instrQ <= asmNext;
                        if (bus.byte_last) begin
                            lastSeen <= 1'b1;
                            if (byteIdx != 2'd3) errQ <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    byteIdx <= '0;
                    asmWord <= '0;
                    if (wordCount != MAX_WORDS) wordCount <= wordCount + WC_ONE;
                    if (loadEnd) holdCnt <= HOLD_LOAD;
                end
                HOLD: begin
                    holdCnt <= holdCnt - HOLD_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready       = byteReady;
    assign bus.LoadInstructions = loadStrobe;
    assign bus.Instruction      = instrQ;
    assign bus.cpu_reset        = cpuReset;
    assign bus.word_count       = wordCount;
    assign bus.busy             = busyQ;
    assign bus.done             = doneQ;
    assign bus.err              = errQ;
endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: three instances (BE/32 words, LE/32 words, BE/4 words) checked
// every cycle against a transaction-level model, plus literal expectations per scenario.
module tb_instr_loader;
    localparam int BH = 2;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    logic        sStart [3];
    logic [7:0]  sByte  [3];
    logic        sValid [3];
    logic        sLast  [3];
    logic        oRdy [3], oLi [3], oCr [3], oBusy [3], oDone [3], oErr [3];
    logic [31:0] oInstr [3];
    logic [5:0]  oWc [3];

    instr_loader_if #(.NUM_WORDS(32)) bus0 ();
    instr_loader_if #(.NUM_WORDS(32)) bus1 ();
    instr_loader_if #(.NUM_WORDS(4))  bus2 ();

    instr_loader #(.NUM_WORDS(32), .BOOT_HOLD(BH), .BIG_ENDIAN(1)) dut0 (.clk(clk), .Reset(Reset), .bus(bus0));
    instr_loader #(.NUM_WORDS(32), .BOOT_HOLD(BH), .BIG_ENDIAN(0)) dut1 (.clk(clk), .Reset(Reset), .bus(bus1));
    instr_loader #(.NUM_WORDS(4),  .BOOT_HOLD(BH), .BIG_ENDIAN(1)) dut2 (.clk(clk), .Reset(Reset), .bus(bus2));

    assign bus0.start = sStart[0]; assign bus0.byte_in = sByte[0];
    assign bus0.byte_valid = sValid[0]; assign bus0.byte_last = sLast[0];
    assign bus1.start = sStart[1]; assign bus1.byte_in = sByte[1];
    assign bus1.byte_valid = sValid[1]; assign bus1.byte_last = sLast[1];
    assign bus2.start = sStart[2]; assign bus2.byte_in = sByte[2];
    assign bus2.byte_valid = sValid[2]; assign bus2.byte_last = sLast[2];

    assign oRdy[0] = bus0.byte_ready; assign oLi[0] = bus0.LoadInstructions;
    assign oCr[0] = bus0.cpu_reset; assign oBusy[0] = bus0.busy; assign oDone[0] = bus0.done;
    assign oErr[0] = bus0.err; assign oInstr[0] = bus0.Instruction; assign oWc[0] = bus0.word_count;
    assign oRdy[1] = bus1.byte_ready; assign oLi[1] = bus1.LoadInstructions;
    assign oCr[1] = bus1.cpu_reset; assign oBusy[1] = bus1.busy; assign oDone[1] = bus1.done;
    assign oErr[1] = bus1.err; assign oInstr[1] = bus1.Instruction; assign oWc[1] = bus1.word_count;
    assign oRdy[2] = bus2.byte_ready; assign oLi[2] = bus2.LoadInstructions;
    assign oCr[2] = bus2.cpu_reset; assign oBusy[2] = bus2.busy; assign oDone[2] = bus2.done;
    assign oErr[2] = bus2.err; assign oInstr[2] = bus2.Instruction; assign oWc[2] = {3'b000, bus2.word_count};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: ph 0=idle 1=loading 2=final word written, waiting for release 3=running
    int          capA [3] = '{32, 32, 4};
    int          beA  [3] = '{1, 0, 1};
    int          ph [3], idx [3], cnt [3], pendDue [3], runAt [3], primeAt [3];
    logic [31:0] acc [3], pendWord [3], lastI [3];
    bit          pendFinal [3], mErr [3];
    logic [31:0] strobeLog [3][8];
    int          strobeN [3], strobeCyc [3], doneCyc [3];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h cyc=%0d", nm, k, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input int k, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%b want=%b cyc=%0d", nm, k, act, exp, cyc);
        end
    endtask

    task automatic runChecks(input int k);
        chk1("busy", k, oBusy[k], 1'b0);
        chk1("done", k, oDone[k], 1'b1);
        chk1("cpu_reset", k, oCr[k], 1'b0);
        chk1("ready_run", k, oRdy[k], 1'b0);
        chk1("strobe_run", k, oLi[k], 1'b0);
        chk1("err_run", k, oErr[k], mErr[k]);
        chk("wc_run", k, {26'd0, oWc[k]}, cnt[k]);
    endtask

    task automatic checkOne(input int k);
        int sh;
        if (Reset) begin
            chk1("rst_ready", k, oRdy[k], 1'b0);
            chk1("rst_strobe", k, oLi[k], 1'b0);
            chk("rst_instr", k, oInstr[k], 32'h0);
            chk1("rst_cpu_reset", k, oCr[k], 1'b1);
            chk("rst_wc", k, {26'd0, oWc[k]}, 32'd0);
            chk1("rst_busy", k, oBusy[k], 1'b0);
            chk1("rst_done", k, oDone[k], 1'b0);
            chk1("rst_err", k, oErr[k], 1'b0);
            ph[k] = 0; cnt[k] = 0; pendDue[k] = -1; lastI[k] = 0; mErr[k] = 0;
            return;
        end
        if (!oLi[k]) chk("instr_hold", k, oInstr[k], lastI[k]);
        case (ph[k])
            0: begin
                chk1("idle_busy", k, oBusy[k], 1'b0);
                chk1("idle_done", k, oDone[k], 1'b0);
                chk1("idle_cpu_reset", k, oCr[k], 1'b1);
                chk1("idle_ready", k, oRdy[k], 1'b0);
                chk1("idle_strobe", k, oLi[k], 1'b0);
            end
            1: begin
                chk1("load_busy", k, oBusy[k], 1'b1);
                chk1("load_done", k, oDone[k], 1'b0);
                chk1("load_cpu_reset", k, oCr[k], 1'b1);
                if (pendDue[k] == cyc) begin
                    chk1("strobe", k, oLi[k], 1'b1);
                    chk1("write_ready", k, oRdy[k], 1'b0);
                    chk("word", k, oInstr[k], pendWord[k]);
                    chk("wc_at_strobe", k, {26'd0, oWc[k]}, cnt[k]);
                    lastI[k] = pendWord[k];
                    if (strobeN[k] < 8) strobeLog[k][strobeN[k]] = oInstr[k];
                    strobeN[k]++;
                    strobeCyc[k] = cyc;
                    cnt[k]++;
                    pendDue[k] = -1;
                    if (pendFinal[k]) begin
                        ph[k] = 2;
                        runAt[k] = cyc + BH + 1;
                    end
                end else begin
                    chk1("no_strobe", k, oLi[k], 1'b0);
                    chk1("collect_ready", k, oRdy[k], (cyc == primeAt[k]) ? 1'b0 : 1'b1);
                end
            end
            2: begin
                if (cyc < runAt[k]) begin
                    chk1("hold_busy", k, oBusy[k], 1'b1);
                    chk1("hold_done", k, oDone[k], 1'b0);
                    chk1("hold_cpu_reset", k, oCr[k], 1'b1);
                    chk1("hold_ready", k, oRdy[k], 1'b0);
                    chk1("hold_strobe", k, oLi[k], 1'b0);
                    chk1("hold_err", k, oErr[k], mErr[k]);
                    chk("hold_wc", k, {26'd0, oWc[k]}, cnt[k]);
                end else begin
                    ph[k] = 3;
                    doneCyc[k] = cyc;
                    runChecks(k);
                end
            end
            default: runChecks(k);
        endcase
        // effects of this cycle's inputs, visible from the next cycle
        if ((ph[k] == 0 || ph[k] == 3) && sStart[k]) begin
            ph[k] = 1; primeAt[k] = cyc + 1; idx[k] = 0; acc[k] = 0; cnt[k] = 0;
            mErr[k] = 0; pendDue[k] = -1; strobeN[k] = 0;
        end else if (ph[k] == 1 && sValid[k] && oRdy[k]) begin
            sh = (beA[k] != 0) ? (3 - idx[k]) * 8 : idx[k] * 8;
            acc[k] = acc[k] | ({24'd0, sByte[k]} << sh);
            if (idx[k] == 3 || sLast[k]) begin
                pendWord[k]  = acc[k];
                pendDue[k]   = cyc + 1;
                pendFinal[k] = sLast[k] || (cnt[k] + 1 == capA[k]);
                if (sLast[k] && idx[k] != 3) mErr[k] = 1;
                acc[k] = 0;
                idx[k] = 0;
            end else begin
                idx[k]++;
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) checkOne(k);
    end

    task automatic pulseStart(input int k);
        sStart[k] = 1'b1;
        @(posedge clk); #1;
        sStart[k] = 1'b0;
    endtask

    task automatic sendByte(input int k, input logic [7:0] b, input bit last, input int gap);
        int t;
        repeat (gap) begin @(posedge clk); #1; end
        sByte[k] = b; sLast[k] = last; sValid[k] = 1'b1;
        t = 0;
        @(negedge clk);
        while (!oRdy[k] && t < 100) begin @(negedge clk); t++; end
        if (!oRdy[k]) begin
            total++; bad++;
            $display("FAIL send_timeout dut%0d byte=%h got=not-accepted want=accepted", k, b);
        end
        @(posedge clk); #1;
        sValid[k] = 1'b0; sLast[k] = 1'b0;
    endtask

    task automatic waitDone(input int k);
        int t = 0;
        @(negedge clk);
        while (!oDone[k] && t < 200) begin @(negedge clk); t++; end
        if (!oDone[k]) begin
            total++; bad++;
            $display("FAIL done_timeout dut%0d got=0 want=1", k);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted, bi;
        logic xf;
        logic [7:0] g6 [8];
        g6[0] = 8'h12; g6[1] = 8'h34; g6[2] = 8'h56; g6[3] = 8'h78;
        g6[4] = 8'h9A; g6[5] = 8'hBC; g6[6] = 8'hDE; g6[7] = 8'hF0;
        for (int k = 0; k < 3; k++) begin
            sStart[k] = 0; sByte[k] = 0; sValid[k] = 0; sLast[k] = 0;
            strobeN[k] = 0; strobeCyc[k] = 0; doneCyc[k] = 0;
        end
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 Reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // two big-endian words
        pulseStart(0);
        sendByte(0, 8'h20, 0, 0); sendByte(0, 8'h08, 0, 0);
        sendByte(0, 8'h00, 0, 0); sendByte(0, 8'h05, 0, 0);
        for (int i = 0; i < 4; i++) sendByte(0, 8'h00, i == 3, 0);
        waitDone(0);
        chk("t1_word0", 0, strobeLog[0][0], 32'h20080005);
        chk("t1_word1", 0, strobeLog[0][1], 32'h00000000);
        chk("t1_nstrobe", 0, strobeN[0], 32'd2);
        chk("t1_wc", 0, {26'd0, oWc[0]}, 32'd2);
        chk1("t1_err", 0, oErr[0], 1'b0);
        chk("t1_release", 0, doneCyc[0] - strobeCyc[0], 32'd3);

        // little-endian lane order
        pulseStart(1);
        sendByte(1, 8'h05, 0, 0); sendByte(1, 8'h00, 0, 0);
        sendByte(1, 8'h08, 0, 0); sendByte(1, 8'h20, 1, 0);
        waitDone(1);
        chk("t2_word", 1, strobeLog[1][0], 32'h20080005);
        chk("t2_nstrobe", 1, strobeN[1], 32'd1);

        // short final word, reloaded from RUN
        pulseStart(0);
        sendByte(0, 8'hAA, 0, 0); sendByte(0, 8'hBB, 1, 0);
        waitDone(0);
        chk("t3_word", 0, strobeLog[0][0], 32'hAABB0000);
        chk1("t3_err", 0, oErr[0], 1'b1);
        chk1("t3_done", 0, oDone[0], 1'b1);

        // word cap of 4 with valid held high over 20 bytes
        pulseStart(2);
        accepted = 0; bi = 0;
        sByte[2] = 8'h01; sLast[2] = 0; sValid[2] = 1;
        repeat (60) begin
            @(negedge clk); xf = oRdy[2];
            @(posedge clk); #1;
            if (xf) begin
                accepted++; bi++;
                if (bi < 20) begin sByte[2] = 8'(bi + 1); sLast[2] = (bi == 19); end
                else sValid[2] = 0;
            end
        end
        sValid[2] = 0; sLast[2] = 0;
        chk("t4_accepted", 2, accepted, 32'd16);
        chk("t4_nstrobe", 2, strobeN[2], 32'd4);
        chk("t4_word3", 2, strobeLog[2][3], 32'h0D0E0F10);
        chk("t4_wc", 2, {26'd0, oWc[2]}, 32'd4);
        chk1("t4_done", 2, oDone[2], 1'b1);
        chk1("t4_err", 2, oErr[2], 1'b0);

        // reset mid-word, then a clean reload
        pulseStart(0);
        sendByte(0, 8'h11, 0, 0); sendByte(0, 8'h22, 0, 0);
        @(posedge clk); #1 Reset = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 Reset = 1'b0;
        chk("t5_nstrobe", 0, strobeN[0], 32'd0);
        chk("t5_instr", 0, oInstr[0], 32'h0);
        pulseStart(0);
        sendByte(0, 8'h20, 0, 0); sendByte(0, 8'h08, 0, 0);
        sendByte(0, 8'h00, 0, 0); sendByte(0, 8'h05, 1, 0);
        waitDone(0);
        chk("t5_word", 0, strobeLog[0][0], 32'h20080005);
        chk("t5_wc", 0, {26'd0, oWc[0]}, 32'd1);

        // random gaps, start ignored mid-load, then reload from RUN
        pulseStart(0);
        for (int i = 0; i < 8; i++) begin
            sendByte(0, g6[i], i == 7, $urandom_range(3, 0));
            if (i == 1) pulseStart(0);
        end
        waitDone(0);
        chk("t6_word0", 0, strobeLog[0][0], 32'h12345678);
        chk("t6_word1", 0, strobeLog[0][1], 32'h9ABCDEF0);
        chk("t6_nstrobe", 0, strobeN[0], 32'd2);
        chk1("t6_err", 0, oErr[0], 1'b0);
        pulseStart(0);
        sendByte(0, 8'h01, 0, 1); sendByte(0, 8'h02, 0, 0);
        sendByte(0, 8'h03, 0, 2); sendByte(0, 8'h04, 1, 0);
        waitDone(0);
        chk("t6_reload_word", 0, strobeLog[0][0], 32'h01020304);
        chk("t6_reload_wc", 0, {26'd0, oWc[0]}, 32'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
